// File: rtl/pid_lock_ctrl.sv
// Purpose : PDH laser lock supervisor: sweeps the DAC to find a resonance, hands
//           control to the PID core, confirms lock and watches for loss of lock.
// Latency : all outputs registered; inputs seen at edge N are reflected after edge N.
// Backpressure: none; free-running control loop with no handshake.
//
// Ports:
//   clk, rst          sole clock, synchronous active-high reset
//   enable_i          run request; low forces IDLE
//   err_i             signed PDH error (same stream as the PID core)
//   pid_out_i         PID core output, midscale = zero correction
//   sweep_*_i         sweep bounds (inclusive), step size and step divider
//   lock_thr_i        |err| capture/confirm threshold
//   settle_i          CAPTURE dwell, loss_cnt_i = rail cycles declaring loss
//   dac_o, pid_en_o, locked_o, state_o   registered control outputs
//
// Build option: define PID_LOCK_AUTO_RELOCK_EN to resweep on loss of lock
// instead of parking in FAULT.
module pid_lock_ctrl #(
    parameter int SWEEP_W = 14,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic signed [15:0]        err_i,
    input  logic        [SWEEP_W-1:0] pid_out_i,
    input  logic        [SWEEP_W-1:0] sweep_min_i,
    input  logic        [SWEEP_W-1:0] sweep_max_i,
    input  logic        [7:0]         sweep_step_i,
    input  logic        [CNT_W-1:0]   sweep_div_i,
    input  logic        [15:0]        lock_thr_i,
    input  logic        [CNT_W-1:0]   settle_i,
    input  logic        [CNT_W-1:0]   loss_cnt_i,
    output logic        [SWEEP_W-1:0] dac_o,
    output logic                      pid_en_o,
    output logic                      locked_o,
    output logic        [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWEEP   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int PW = SWEEP_W + 1;
    localparam logic [SWEEP_W-1:0]        MID   = {1'b0, {(SWEEP_W-1){1'b1}}};
    localparam logic [SWEEP_W-1:0]        RAIL  = {SWEEP_W{1'b1}};
    localparam logic signed [SWEEP_W+1:0] MID_S = {2'b00, MID};
    localparam logic signed [SWEEP_W+1:0] MAX_S = {2'b00, RAIL};

    state_t             state_q;
    logic [SWEEP_W-1:0] pos_q;
    logic [SWEEP_W-1:0] hold_q;
    logic               dir_up_q;
    logic [CNT_W-1:0]   step_cnt_q;
    logic [CNT_W-1:0]   settle_cnt_q;
    logic [CNT_W-1:0]   rail_cnt_q;
    logic [SWEEP_W-1:0] dac_q;
    logic               pid_en_q;
    logic               locked_q;

    // |err| with the most negative code folded onto the largest positive one
    logic [15:0] err_u;
    logic [15:0] abs_err;
    logic        in_win;

    always_comb begin
        err_u = err_i;
        if (err_u == 16'h8000) begin
            abs_err = 16'h7FFF;
        end else if (err_u[15]) begin
            abs_err = ~err_u + 16'd1;
        end else begin
            abs_err = err_u;
        end
        in_win = (abs_err <= lock_thr_i);
    end

    // Next sweep position, evaluated one bit wider so pos+step never wraps
    logic [PW-1:0]      pos_ext, min_ext, max_ext, step_ext, up_sum, down_dif;
    logic               sweep_degen;
    logic [SWEEP_W-1:0] pos_d;
    logic               dir_up_d;

    always_comb begin
        pos_ext     = {1'b0, pos_q};
        min_ext     = {1'b0, sweep_min_i};
        max_ext     = {1'b0, sweep_max_i};
        step_ext    = {{(PW-8){1'b0}}, sweep_step_i};
        up_sum      = pos_ext + step_ext;
        down_dif    = pos_ext - step_ext;
        sweep_degen = (sweep_min_i >= sweep_max_i) || (sweep_step_i == 8'd0);
        pos_d       = pos_q;
        dir_up_d    = dir_up_q;
        if (sweep_degen) begin
            pos_d = sweep_min_i;
        end else if (dir_up_q) begin
            if (up_sum > max_ext) begin
                pos_d    = sweep_max_i;
                dir_up_d = 1'b0;
            end else begin
                pos_d = up_sum[SWEEP_W-1:0];
            end
        end else begin
            // pos - step < min, rearranged to avoid an underflowing subtract
            if (pos_ext < min_ext + step_ext) begin
                pos_d    = sweep_min_i;
                dir_up_d = 1'b1;
            end else begin
                pos_d = down_dif[SWEEP_W-1:0];
            end
        end
    end

    // DAC drive while the PID core is engaged: base + (pid - midscale), clipped
    function automatic logic [SWEEP_W-1:0] corr_dac(input logic [SWEEP_W-1:0] base,
                                                    input logic [SWEEP_W-1:0] pid);
        logic signed [SWEEP_W+1:0] s;
        s = $signed({2'b00, base}) + $signed({2'b00, pid}) - MID_S;
        if (s[SWEEP_W+1]) begin
            return '0;
        end else if (s > MAX_S) begin
            return RAIL;
        end else begin
            return s[SWEEP_W-1:0];
        end
    endfunction

    // Loss-of-lock rail detection; a zero threshold behaves like one
    logic             pid_rail;
    logic [CNT_W:0]   rail_inc;
    logic [CNT_W-1:0] loss_eff;
    logic             loss_hit;

    always_comb begin
        pid_rail = (pid_out_i == '0) || (pid_out_i == RAIL);
        rail_inc = {1'b0, rail_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        loss_eff = (loss_cnt_i == '0) ? CNT_W'(1) : loss_cnt_i;
        loss_hit = (rail_inc >= {1'b0, loss_eff});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pos_q        <= '0;
            hold_q       <= '0;
            dir_up_q     <= 1'b1;
            step_cnt_q   <= '0;
            settle_cnt_q <= '0;
            rail_cnt_q   <= '0;
            dac_q        <= MID;
            pid_en_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else if (!enable_i) begin
            state_q      <= ST_IDLE;
            step_cnt_q   <= '0;
            settle_cnt_q <= '0;
            rail_cnt_q   <= '0;
            dac_q        <= MID;
            pid_en_q     <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_SWEEP;
                    pos_q      <= sweep_min_i;
                    dir_up_q   <= 1'b1;
                    step_cnt_q <= '0;
                    dac_q      <= sweep_min_i;
                    pid_en_q   <= 1'b0;
                    locked_q   <= 1'b0;
                end
                ST_SWEEP: begin
                    locked_q <= 1'b0;
                    if (in_win) begin
                        // Freeze the position currently on the DAC and hand over
                        state_q      <= ST_CAPTURE;
                        hold_q       <= pos_q;
                        settle_cnt_q <= '0;
                        dac_q        <= corr_dac(pos_q, pid_out_i);
                        pid_en_q     <= 1'b1;
                    end else begin
                        pid_en_q <= 1'b0;
                        if (step_cnt_q >= sweep_div_i) begin
                            step_cnt_q <= '0;
                            pos_q      <= pos_d;
                            dir_up_q   <= dir_up_d;
                            dac_q      <= pos_d;
                        end else begin
                            step_cnt_q <= step_cnt_q + CNT_W'(1);
                            dac_q      <= pos_q;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (settle_cnt_q >= settle_i) begin
                        if (in_win) begin
                            state_q    <= ST_LOCKED;
                            rail_cnt_q <= '0;
                            dac_q      <= corr_dac(hold_q, pid_out_i);
                            pid_en_q   <= 1'b1;
                            locked_q   <= 1'b1;
                        end else begin
                            // Resume sweeping where capture started, same direction
                            state_q  <= ST_SWEEP;
                            pos_q    <= hold_q;
                            dac_q    <= hold_q;
                            pid_en_q <= 1'b0;
                            locked_q <= 1'b0;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + CNT_W'(1);
                        dac_q        <= corr_dac(hold_q, pid_out_i);
                        pid_en_q     <= 1'b1;
                        locked_q     <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (pid_rail && loss_hit) begin
                        rail_cnt_q <= '0;
                        dac_q      <= hold_q;
                        pid_en_q   <= 1'b0;
                        locked_q   <= 1'b0;
`ifdef PID_LOCK_AUTO_RELOCK_EN
                        state_q    <= ST_SWEEP;
                        pos_q      <= hold_q;
                        dir_up_q   <= 1'b1;
                        step_cnt_q <= '0;
`else
                        state_q    <= ST_FAULT;
`endif
                    end else begin
                        rail_cnt_q <= pid_rail ? rail_inc[CNT_W-1:0] : '0;
                        dac_q      <= corr_dac(hold_q, pid_out_i);
                        pid_en_q   <= 1'b1;
                        locked_q   <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Park at the last good operating point until enable drops
                    dac_q    <= hold_q;
                    pid_en_q <= 1'b0;
                    locked_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    dac_q    <= MID;
                    pid_en_q <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign dac_o    = dac_q;
    assign pid_en_o = pid_en_q;
    assign locked_o = locked_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_pid_lock_ctrl.sv
// Purpose : self-checking bench for pid_lock_ctrl using an expected-output queue.
// Latency : one registered cycle per check; every check is a fixed number of edges.
// Backpressure: not applicable.
module tb_pid_lock_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable_i;
    logic signed [15:0] err_i;
    logic [13:0]        pid_out_i, sweep_min_i, sweep_max_i;
    logic [7:0]         sweep_step_i;
    logic [15:0]        sweep_div_i, lock_thr_i, settle_i, loss_cnt_i;
    logic [13:0]        dac_o;
    logic               pid_en_o, locked_o;
    logic [2:0]         state_o;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] dac;
        logic        en;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pid_lock_ctrl #(.SWEEP_W(14), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .err_i(err_i),
        .pid_out_i(pid_out_i), .sweep_min_i(sweep_min_i), .sweep_max_i(sweep_max_i),
        .sweep_step_i(sweep_step_i), .sweep_div_i(sweep_div_i), .lock_thr_i(lock_thr_i),
        .settle_i(settle_i), .loss_cnt_i(loss_cnt_i), .dac_o(dac_o),
        .pid_en_o(pid_en_o), .locked_o(locked_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int st, input int dac, input int en, input int lk);
        exp_t v;
        v.st  = st[2:0];
        v.dac = dac[13:0];
        v.en  = en[0];
        v.lk  = lk[0];
        return v;
    endfunction

    function automatic exp_t obs();
        exp_t v;
        v.st  = state_o;
        v.dac = dac_o;
        v.en  = pid_en_o;
        v.lk  = locked_o;
        return v;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("st=%0d dac=%0d en=%b lk=%b", v.st, v.dac, v.en, v.lk);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        enable_i = 1'b0;
        tick();
    endtask

    task automatic set_sweep(input int mn, input int mx, input int stp, input int dv);
        sweep_min_i  = mn[13:0];
        sweep_max_i  = mx[13:0];
        sweep_step_i = stp[7:0];
        sweep_div_i  = dv[15:0];
    endtask

    // Brings the DUT to LOCKED with hold = h (pid at midscale, settle 2)
    task automatic go_locked(input int h);
        set_sweep(h, h + 100, 1, 0);
        err_i = 16'sd20; lock_thr_i = 16'd50; settle_i = 16'd2;
        pid_out_i = 14'd8191; loss_cnt_i = 16'd5;
        enable_i = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        exp_t e, g;
        rst = 1'b1; enable_i = 1'b1;
        set_sweep(100, 110, 4, 0);
        err_i = 16'sd2000; lock_thr_i = 16'd50; pid_out_i = 14'd8191;
        settle_i = 16'd8; loss_cnt_i = 16'd5;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(0, 8191, 0, 0));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        rst = 1'b0; enable_i = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        exp_t e, g;
        int seq[8] = '{100, 104, 108, 110, 106, 102, 100, 104};
        set_sweep(100, 110, 4, 0);
        err_i = 16'sd2000; lock_thr_i = 16'd50;
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(mk(1, seq[i], 0, 0));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        enable_i = 1'b0;
        sb.push_back(mk(0, 8191, 0, 0));
        tick();
        g = obs(); e = sb.pop_front(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL sweep_disable: got %s, want %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_step_rate();
        exp_t e, g;
        set_sweep(0, 1000, 1, 3);
        err_i = 16'sd2000; lock_thr_i = 16'd50;
        enable_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            sb.push_back(mk(1, (k - 1) / 4, 0, 0));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL step_rate[%0d]: got %s, want %s", k, fmt(g), fmt(e));
            end
        end
        to_idle();
    endtask

    task automatic test_capture_lock();
        exp_t e, g;
        set_sweep(500, 600, 1, 0);
        err_i = 16'sd20; lock_thr_i = 16'd50; settle_i = 16'd8; pid_out_i = 14'd8200;
        enable_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      sb.push_back(mk(1, 500, 0, 0));
            else if (i < 10) sb.push_back(mk(2, 509, 1, 0));
            else             sb.push_back(mk(3, 509, 1, 1));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL capture_lock[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        to_idle();
    endtask

    task automatic test_fail_confirm();
        exp_t e, g;
        set_sweep(500, 600, 1, 0);
        err_i = 16'sd20; lock_thr_i = 16'd50; settle_i = 16'd3; pid_out_i = 14'd8191;
        enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) err_i = 16'sd3000;
            if (i == 0)      sb.push_back(mk(1, 500, 0, 0));
            else if (i < 5)  sb.push_back(mk(2, 500, 1, 0));
            else             sb.push_back(mk(1, 500 + (i - 5), 0, 0));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL fail_confirm[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        to_idle();
    endtask

    task automatic test_loss();
        exp_t e, g;
        go_locked(500);
        for (int i = 0; i < 10; i++) begin
            pid_out_i = (i == 4) ? 14'd8000 : 14'd16383;
            if (i == 4)      sb.push_back(mk(3, 309, 1, 1));
            else if (i < 9)  sb.push_back(mk(3, 8692, 1, 1));
`ifdef PID_LOCK_AUTO_RELOCK_EN
            else             sb.push_back(mk(1, 500, 0, 0));
`else
            else             sb.push_back(mk(4, 500, 0, 0));
`endif
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL loss[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
`ifdef PID_LOCK_AUTO_RELOCK_EN
        err_i = 16'sd3000; pid_out_i = 14'd8191;
        sb.push_back(mk(1, 501, 0, 0));
        tick();
        g = obs(); e = sb.pop_front(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL loss_resweep: got %s, want %s", fmt(g), fmt(e));
        end
`else
        pid_out_i = 14'd8000;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(4, 500, 0, 0));
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL fault_hold[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
`endif
        enable_i = 1'b0;
        sb.push_back(mk(0, 8191, 0, 0));
        tick();
        g = obs(); e = sb.pop_front(); n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL loss_exit: got %s, want %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_enable_reset();
        exp_t e, g;
        go_locked(500);
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin enable_i = 1'b0; sb.push_back(mk(0, 8191, 0, 0)); end
                1: begin
                    set_sweep(100, 110, 4, 0);
                    err_i = 16'sd2000; enable_i = 1'b1;
                    sb.push_back(mk(1, 100, 0, 0));
                end
                2: sb.push_back(mk(1, 104, 0, 0));
                3: begin rst = 1'b1; sb.push_back(mk(0, 8191, 0, 0)); end
                4: begin rst = 1'b0; sb.push_back(mk(1, 100, 0, 0)); end
                default: sb.push_back(mk(1, 104, 0, 0));
            endcase
            tick();
            g = obs(); e = sb.pop_front(); n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL enable_reset[%0d]: got %s, want %s", i, fmt(g), fmt(e));
            end
        end
        to_idle();
    endtask

    // Degenerate sweeps, |err| edge cases and DAC saturation
    task automatic test_bounds();
        exp_t e, g;
        int mn[6]   = '{200, 200, 300, 300, 500, 9000};
        int mx[6]   = '{200, 300, 400, 400, 600, 9100};
        int stp[6]  = '{4, 0, 1, 1, 1, 1};
        int thr[6]  = '{50, 50, 32767, 32766, 50, 50};
        int errv[6] = '{2000, 2000, -32768, -32768, -50, 20};
        int pid[6]  = '{8191, 8191, 8191, 8191, 0, 16383};
        int ex1[6]  = '{200, 200, 300, 300, 500, 9000};
        int ex2[6]  = '{200, 200, 300, 301, 0, 16383};
        int st2[6]  = '{1, 1, 2, 1, 2, 2};
        for (int c = 0; c < 6; c++) begin
            set_sweep(mn[c], mx[c], stp[c], 0);
            lock_thr_i = thr[c][15:0]; err_i = errv[c][15:0];
            pid_out_i = pid[c][13:0]; settle_i = 16'd20;
            enable_i = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (i == 0)      sb.push_back(mk(1, ex1[c], 0, 0));
                else if (c < 2)  sb.push_back(mk(1, ex1[c], 0, 0));
                else if (i == 1) sb.push_back(mk(st2[c], ex2[c], (st2[c] == 2) ? 1 : 0, 0));
                else             break;
                tick();
                g = obs(); e = sb.pop_front(); n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL bounds[%0d.%0d]: got %s, want %s", c, i, fmt(g), fmt(e));
                end
            end
            to_idle();
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_step_rate();
        test_capture_lock();
        test_fail_confirm();
        test_loss();
        test_enable_reset();
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
